// File: rtl/fwrd_bypass_net.sv
// Operand bypass network: live execute results plus a short result history,
// resolved youngest-first per consumer source with an x0 filter.
module fwrd_bypass_net #(
  parameter int NUM_FUS = 4,
  parameter int NUM_RD  = 4,
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_FUS-1:0]        ex_valid,
  input  logic [NUM_FUS*REG_W-1:0]  ex_dst,
  input  logic [NUM_FUS*XLEN-1:0]   ex_val,
  input  logic [NUM_RD-1:0]         rd_req,
  input  logic [NUM_RD*REG_W-1:0]   src1_reg,
  input  logic [NUM_RD*REG_W-1:0]   src2_reg,
  output logic [NUM_RD-1:0]         src1_hit,
  output logic [NUM_RD-1:0]         src2_hit,
  output logic [NUM_RD*XLEN-1:0]    src1_val,
  output logic [NUM_RD*XLEN-1:0]    src2_val,
  output logic [CNT_W-1:0]          hit_cnt
);

  localparam int NCAND = NUM_FUS * (DEPTH + 1);

  // Candidates ordered by age, then FU index: index 0 has top priority.
  logic [NCAND-1:0]       cand_v;
  logic [NCAND*REG_W-1:0] cand_d;
  logic [NCAND*XLEN-1:0]  cand_x;

  assign cand_v[NUM_FUS-1:0]         = ex_valid;
  assign cand_d[NUM_FUS*REG_W-1:0]   = ex_dst;
  assign cand_x[NUM_FUS*XLEN-1:0]    = ex_val;

  generate
    if (DEPTH > 0) begin : g_hist
      logic [NUM_FUS-1:0]       hv [DEPTH];
      logic [NUM_FUS*REG_W-1:0] hd [DEPTH];
      logic [NUM_FUS*XLEN-1:0]  hx [DEPTH];

      // Shift results down the history; flush kills every valid bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            hv[k] <= '0;
            hd[k] <= '0;
            hx[k] <= '0;
          end
        end else begin
          hv[0] <= flush ? '0 : ex_valid;
          hd[0] <= ex_dst;
          hx[0] <= ex_val;
          for (int k = 1; k < DEPTH; k++) begin
            hv[k] <= flush ? '0 : hv[k-1];
            hd[k] <= hd[k-1];
            hx[k] <= hx[k-1];
          end
        end
      end

      for (genvar k = 0; k < DEPTH; k++) begin : g_cand
        assign cand_v[(k+1)*NUM_FUS +: NUM_FUS]             = hv[k];
        assign cand_d[(k+1)*NUM_FUS*REG_W +: NUM_FUS*REG_W] = hd[k];
        assign cand_x[(k+1)*NUM_FUS*XLEN +: NUM_FUS*XLEN]   = hx[k];
      end
    end
  endgenerate

  // Scan oldest to youngest so the highest-priority match is written last.
  always_comb begin
    src1_hit = '0;
    src2_hit = '0;
    src1_val = '0;
    src2_val = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_req[p] && src1_reg[p*REG_W +: REG_W] != '0) begin
        for (int c = NCAND - 1; c >= 0; c--) begin
          if (cand_v[c] &&
              cand_d[c*REG_W +: REG_W] == src1_reg[p*REG_W +: REG_W]) begin
            src1_hit[p] = 1'b1;
            src1_val[p*XLEN +: XLEN] = cand_x[c*XLEN +: XLEN];
          end
        end
      end
      if (rd_req[p] && src2_reg[p*REG_W +: REG_W] != '0) begin
        for (int c = NCAND - 1; c >= 0; c--) begin
          if (cand_v[c] &&
              cand_d[c*REG_W +: REG_W] == src2_reg[p*REG_W +: REG_W]) begin
            src2_hit[p] = 1'b1;
            src2_val[p*XLEN +: XLEN] = cand_x[c*XLEN +: XLEN];
          end
        end
      end
    end
  end

  logic [CNT_W-1:0] hit_inc;

  // Number of operands forwarded this cycle.
  always_comb begin
    hit_inc = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      hit_inc = hit_inc + CNT_W'(src1_hit[p]) + CNT_W'(src2_hit[p]);
    end
  end

  // Free-running forwarded-operand counter; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
    end else begin
      hit_cnt <= hit_cnt + hit_inc;
    end
  end

endmodule

// File: tb/tb_fwrd_bypass_net.sv
// Directed bench for fwrd_bypass_net: per-cycle vector table plus
// an asynchronous-reset sequence.
module tb_fwrd_bypass_net;

  localparam int NF = 4;
  localparam int NR = 4;
  localparam int XL = 32;
  localparam int RW = 5;
  localparam int DP = 2;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NF-1:0]     ex_valid;
  logic [NF*RW-1:0]  ex_dst;
  logic [NF*XL-1:0]  ex_val;
  logic [NR-1:0]     rd_req;
  logic [NR*RW-1:0]  src1_reg;
  logic [NR*RW-1:0]  src2_reg;
  logic [NR-1:0]     src1_hit;
  logic [NR-1:0]     src2_hit;
  logic [NR*XL-1:0]  src1_val;
  logic [NR*XL-1:0]  src2_val;
  logic [CW-1:0]     hit_cnt;

  fwrd_bypass_net #(
    .NUM_FUS(NF), .NUM_RD(NR), .XLEN(XL),
    .REG_W(RW), .DEPTH(DP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_val(ex_val),
    .rd_req(rd_req), .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_hit(src1_hit), .src2_hit(src2_hit),
    .src1_val(src1_val), .src2_val(src2_val),
    .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NF-1:0] ev;
    logic [RW-1:0] ed [NF];
    logic [XL-1:0] ex [NF];
    logic          fl;
    logic [NR-1:0] req;
    logic [RW-1:0] s1 [NR];
    logic [RW-1:0] s2 [NR];
    logic [NR-1:0] h1;
    logic [NR-1:0] h2;
    logic [XL-1:0] v1 [NR];
    logic [XL-1:0] v2 [NR];
  } vec_t;

  vec_t   vq [$];
  vec_t   r;
  int     total = 0;
  int     bad = 0;
  logic [CW-1:0] cnt_model;

  function automatic vec_t blank();
    vec_t b;
    b.ev = '0;
    b.fl = 1'b0;
    b.req = '0;
    b.h1 = '0;
    b.h2 = '0;
    for (int i = 0; i < NF; i++) begin
      b.ed[i] = '0;
      b.ex[i] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      b.s1[i] = '0;
      b.s2[i] = '0;
      b.v1[i] = '0;
      b.v2[i] = '0;
    end
    return b;
  endfunction

  task automatic drive(input vec_t d);
    flush = d.fl;
    ex_valid = d.ev;
    rd_req = d.req;
    for (int i = 0; i < NF; i++) begin
      ex_dst[i*RW +: RW] = d.ed[i];
      ex_val[i*XL +: XL] = d.ex[i];
    end
    for (int i = 0; i < NR; i++) begin
      src1_reg[i*RW +: RW] = d.s1[i];
      src2_reg[i*RW +: RW] = d.s2[i];
    end
  endtask

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic check_vec(input string nm, input vec_t d);
    logic [NR*XL-1:0] e1;
    logic [NR*XL-1:0] e2;
    for (int i = 0; i < NR; i++) begin
      e1[i*XL +: XL] = d.v1[i];
      e2[i*XL +: XL] = d.v2[i];
    end
    check({nm, ".h1"}, longint'(src1_hit), longint'(d.h1));
    check({nm, ".h2"}, longint'(src2_hit), longint'(d.h2));
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s.v1[%0d]", nm, i),
            longint'(src1_val[i*XL +: XL]), longint'(e1[i*XL +: XL]));
      check($sformatf("%s.v2[%0d]", nm, i),
            longint'(src2_val[i*XL +: XL]), longint'(e2[i*XL +: XL]));
    end
    check({nm, ".cnt"}, longint'(hit_cnt), longint'(cnt_model));
  endtask

  function automatic int pc(input logic [NR-1:0] x);
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(x[i]);
    return n;
  endfunction

  initial begin
    // R0: no producers -> miss
    r = blank(); r.req = 4'b0001; r.s1[0] = 5; vq.push_back(r);
    // R1: FU1 live dst5, both sources hit
    r = blank(); r.ev[1] = 1; r.ed[1] = 5; r.ex[1] = 32'hAAAA;
    r.req = 4'b0001; r.s1[0] = 5; r.s2[0] = 5;
    r.h1 = 4'b0001; r.h2 = 4'b0001;
    r.v1[0] = 32'hAAAA; r.v2[0] = 32'hAAAA; vq.push_back(r);
    // R2: rd_req=0 masks an age-1 match
    r = blank(); r.s1[0] = 5; r.s2[0] = 5; vq.push_back(r);
    // R3: FU0 dst7=1 live; dst5 now at age 2
    r = blank(); r.ev[0] = 1; r.ed[0] = 7; r.ex[0] = 32'h1;
    r.req = 4'b0011; r.s1[0] = 7; r.s1[1] = 5;
    r.h1 = 4'b0011; r.v1[0] = 32'h1; r.v1[1] = 32'hAAAA; vq.push_back(r);
    // R4: FU2 dst7=2 live beats age-1 value; dst5 aged out
    r = blank(); r.ev[2] = 1; r.ed[2] = 7; r.ex[2] = 32'h2;
    r.req = 4'b0011; r.s1[0] = 7; r.s1[1] = 5;
    r.h1 = 4'b0001; r.v1[0] = 32'h2; vq.push_back(r);
    // R5: age 1 -> 2
    r = blank(); r.req = 4'b0001; r.s1[0] = 7;
    r.h1 = 4'b0001; r.v1[0] = 32'h2; vq.push_back(r);
    // R6: age 2 -> 2
    r = blank(); r.req = 4'b0001; r.s1[0] = 7;
    r.h1 = 4'b0001; r.v1[0] = 32'h2; vq.push_back(r);
    // R7: beyond history -> miss
    r = blank(); r.req = 4'b0001; r.s1[0] = 7; vq.push_back(r);
    // R8: same-age tie, x0 producer
    r = blank(); r.ev = 4'b1011;
    r.ed[0] = 9; r.ex[0] = 32'h10;
    r.ed[3] = 9; r.ex[3] = 32'h30;
    r.ed[1] = 0; r.ex[1] = 32'hFF;
    r.req = 4'b0011; r.s1[0] = 9; r.s2[0] = 0; r.s1[1] = 0;
    r.h1 = 4'b0001; r.v1[0] = 32'h10; vq.push_back(r);
    // R9: dst4=0x44 produced; tie resolved at age 1
    r = blank(); r.ev[1] = 1; r.ed[1] = 4; r.ex[1] = 32'h44;
    r.req = 4'b0001; r.s2[0] = 9;
    r.h2 = 4'b0001; r.v2[0] = 32'h10; vq.push_back(r);
    // R10: flush cycle: live 0x55 wins, history still readable
    r = blank(); r.fl = 1; r.ev[1] = 1; r.ed[1] = 4; r.ex[1] = 32'h55;
    r.req = 4'b0011; r.s1[0] = 4; r.s2[0] = 9; r.s1[1] = 4;
    r.h1 = 4'b0011; r.h2 = 4'b0001;
    r.v1[0] = 32'h55; r.v1[1] = 32'h55; r.v2[0] = 32'h10; vq.push_back(r);
    // R11: after flush everything misses
    r = blank(); r.req = 4'b0001; r.s1[0] = 4; r.s2[0] = 9; vq.push_back(r);
    // R12: multi-port, port 3 masked by rd_req
    r = blank(); r.ev[3] = 1; r.ed[3] = 12; r.ex[3] = 32'h1234;
    r.req = 4'b0111;
    r.s1[0] = 12; r.s2[0] = 0; r.s1[1] = 3; r.s2[2] = 12;
    r.s1[3] = 12; r.s2[3] = 12;
    r.h1 = 4'b0001; r.h2 = 4'b0100;
    r.v1[0] = 32'h1234; r.v2[2] = 32'h1234; vq.push_back(r);

    rst = 1'b1;
    drive(blank());
    cnt_model = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.cnt", longint'(hit_cnt), 0);
    check("rst.h1", longint'(src1_hit), 0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check_vec($sformatf("row%0d", i), vq[i]);
      cnt_model = cnt_model + CW'(pc(vq[i].h1) + pc(vq[i].h2));
    end

    // Async reset: dst12 sits at age 1, then rst pulses between edges.
    r = blank(); r.req = 4'b0001; r.s1[0] = 12;
    r.h1 = 4'b0001; r.v1[0] = 32'h1234;
    @(negedge clk);
    drive(r);
    #1;
    check_vec("pre_rst", r);
    #1 rst = 1'b1;
    #1;
    check("arst.h1", longint'(src1_hit), 0);
    check("arst.v1", longint'(src1_val[XL-1:0]), 0);
    check("arst.cnt", longint'(hit_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_model = '0;
    r = blank(); r.req = 4'b0001; r.s1[0] = 12;
    drive(r);
    #1;
    check_vec("post_rst", r);
    @(negedge clk);
    #1;
    check("post_rst.cnt", longint'(hit_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
